// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one requester at a time a burst of len+1 beats,
// drives the bus source select while the burst runs, and pulses done/abort at the end.
module bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned SELW     = 3,
    parameter int unsigned BLW      = 4,
    parameter int unsigned IDLE_SEL = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SELW-1:0]   src_sel,
    input  logic [NREQ*BLW-1:0]    burst_len,
    output logic [NREQ-1:0]        gnt,
    output logic [SELW-1:0]        read_en,
    output logic                   xfer_valid,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        abort,
    output logic                   busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [BLW-1:0]  beat_cnt;
    logic [BLW-1:0]  len_q;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [SELW-1:0] win_sel;
    logic [BLW-1:0]  win_len;
    logic            owner_req;
    logic            last_beat;

    // Round-robin search: first set request starting just after the last winner, with wrap.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = (int'(rr_ptr) + i) % int'(NREQ);
            if (!win_found && req[PW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // Pick out the winner's one-hot grant, select code and burst length.
    always_comb begin
        win_oh  = '0;
        win_sel = '0;
        win_len = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_found && (win_idx == PW'(i))) begin
                win_oh[i] = 1'b1;
                win_sel   = src_sel[i*SELW +: SELW];
                win_len   = burst_len[i*BLW +: BLW];
            end
        end
    end

    // The current owner still requesting; the grant vector is one-hot of the owner.
    always_comb begin
        owner_req = |(req & gnt);
        last_beat = (beat_cnt == len_q);
    end

    // Arbitration FSM with registered bus-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= PW'(NREQ - 1);
            beat_cnt   <= '0;
            len_q      <= '0;
            gnt        <= '0;
            read_en    <= SELW'(IDLE_SEL);
            xfer_valid <= 1'b0;
            done       <= '0;
            abort      <= '0;
            busy       <= 1'b0;
        end else begin
            done  <= '0;
            abort <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state      <= ST_XFER;
                        rr_ptr     <= win_idx;
                        len_q      <= win_len;
                        beat_cnt   <= '0;
                        gnt        <= win_oh;
                        read_en    <= win_sel;
                        xfer_valid <= 1'b1;
                        busy       <= 1'b1;
                        if (win_len == '0) begin
                            done <= win_oh;
                        end
                    end
                end
                ST_XFER: begin
                    if (last_beat || !owner_req) begin
                        // Burst complete or owner withdrew: release the bus for one idle cycle.
                        if (!last_beat) begin
                            abort <= gnt;
                        end
                        state      <= ST_IDLE;
                        beat_cnt   <= '0;
                        gnt        <= '0;
                        read_en    <= SELW'(IDLE_SEL);
                        xfer_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + BLW'(1);
                        if ((beat_cnt + BLW'(1)) == len_q) begin
                            done <= gnt;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: burst-plan reference model, directed scenarios, random traffic.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] src_sel;
    logic [15:0] burst_len;
    logic [3:0]  gnt;
    logic [2:0]  read_en;
    logic        xfer_valid;
    logic [3:0]  done;
    logic [3:0]  abort;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    bus_arbiter #(.NREQ(4), .SELW(3), .BLW(4), .IDLE_SEL(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .src_sel    (src_sel),
        .burst_len  (burst_len),
        .gnt        (gnt),
        .read_en    (read_en),
        .xfer_valid (xfer_valid),
        .done       (done),
        .abort      (abort),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model: a granted burst becomes a plan of beats that the bus must replay.
    typedef struct {
        logic [3:0] g;
        logic [2:0] s;
        logic       last;
    } beat_t;

    beat_t      plan[$];
    int         owner = -1;
    int         ptr   = 3;
    logic [3:0] e_gnt   = 4'd0;
    logic [2:0] e_sel   = 3'd3;
    logic       e_xv    = 1'b0;
    logic [3:0] e_done  = 4'd0;
    logic [3:0] e_abort = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        beat_t b;
        int    w;
        int    len;
        e_gnt   = 4'd0;
        e_sel   = 3'd3;
        e_xv    = 1'b0;
        e_done  = 4'd0;
        e_abort = 4'd0;
        if (!rst_n) begin
            plan.delete();
            owner = -1;
            ptr   = 3;
        end else if (owner >= 0 && plan.size() > 0) begin
            if (!req[owner]) begin
                e_abort = 4'(1 << owner);
                plan.delete();
                owner = -1;
            end else begin
                b      = plan.pop_front();
                e_gnt  = b.g;
                e_sel  = b.s;
                e_xv   = 1'b1;
                e_done = b.last ? b.g : 4'd0;
            end
        end else if (owner >= 0) begin
            owner = -1;
        end else if (req != 4'd0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req[(ptr + k) % 4]) w = (ptr + k) % 4;
            end
            ptr   = w;
            owner = w;
            len   = int'(burst_len[w*4 +: 4]);
            for (int n = 0; n <= len; n++) begin
                b.g    = 4'(1 << w);
                b.s    = src_sel[w*3 +: 3];
                b.last = (n == len);
                plan.push_back(b);
            end
            b      = plan.pop_front();
            e_gnt  = b.g;
            e_sel  = b.s;
            e_xv   = 1'b1;
            e_done = b.last ? b.g : 4'd0;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        vectors++;
        if (gnt !== e_gnt || read_en !== e_sel || xfer_valid !== e_xv ||
            done !== e_done || abort !== e_abort || busy !== e_xv) begin
            miscompares++;
            $display("FAIL model t=%0t: got gnt=%b sel=%0d xv=%b done=%b abort=%b busy=%b, expected gnt=%b sel=%0d xv=%b done=%b abort=%b busy=%b",
                     $time, gnt, read_en, xfer_valid, done, abort, busy,
                     e_gnt, e_sel, e_xv, e_done, e_abort, e_xv);
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [3:0] exp_rr [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    initial begin
        logic [3:0] r;
        rst_n     = 1'b0;
        req       = 4'd0;
        src_sel   = 12'd0;
        burst_len = 16'd0;

        // reset values, then stay idle with no requests
        @(negedge clk);
        chk("reset_gnt", 8'(gnt), 8'h0);
        chk("reset_sel", 8'(read_en), 8'h3);
        chk("reset_xv", 8'(xfer_valid), 8'h0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_gnt", 8'(gnt), 8'h0);
        chk("idle_busy", 8'(busy), 8'h0);

        // single burst: requester 1, select 2, four beats
        src_sel[3 +: 3]   = 3'd2;
        burst_len[4 +: 4] = 4'd3;
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("single_gnt", 8'(gnt), 8'b0010);
            chk("single_sel", 8'(read_en), 8'd2);
            chk("single_done", 8'(done), (c == 4) ? 8'b0010 : 8'h0);
        end
        req = 4'd0;
        @(negedge clk);
        chk("single_after_sel", 8'(read_en), 8'd3);
        chk("single_after_gnt", 8'(gnt), 8'h0);

        // round robin over all four with single-beat bursts
        do_reset();
        src_sel   = {3'd3, 3'd2, 3'd1, 3'd0};
        burst_len = 16'd0;
        req       = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rr_gnt", 8'(gnt), 8'(exp_rr[c]));
        end
        req = 4'd0;

        // abort of requester 0 after beat 2, requester 1 takes over
        do_reset();
        burst_len = {4'd0, 4'd0, 4'd0, 4'd7};
        req       = 4'b0011;
        repeat (3) @(negedge clk);
        chk("abort_pre_gnt", 8'(gnt), 8'b0001);
        req = 4'b0010;
        @(negedge clk);
        chk("abort_pulse", 8'(abort), 8'b0001);
        chk("abort_nodone", 8'(done), 8'h0);
        chk("abort_gnt", 8'(gnt), 8'h0);
        @(negedge clk);
        chk("abort_next_gnt", 8'(gnt), 8'b0010);
        req = 4'd0;

        // wrap from pointer 3 and select stability mid-burst
        do_reset();
        burst_len = 16'd0;
        req       = 4'b1000;
        @(negedge clk);
        chk("wrap_g3", 8'(gnt), 8'b1000);
        req = 4'd0;
        @(negedge clk);
        req               = 4'b1001;
        burst_len[0 +: 4] = 4'd3;
        src_sel[0 +: 3]   = 3'd5;
        src_sel[9 +: 3]   = 3'd1;
        @(negedge clk);
        chk("wrap_gnt", 8'(gnt), 8'b0001);
        chk("wrap_sel", 8'(read_en), 8'd5);
        src_sel[0 +: 3]   = 3'd6;
        burst_len[0 +: 4] = 4'd0;
        repeat (2) @(negedge clk);
        chk("stable_sel", 8'(read_en), 8'd5);
        @(negedge clk);
        chk("stable_done", 8'(done), 8'b0001);
        req = 4'd0;
        @(negedge clk);

        // asynchronous reset in beat 5 of a 16-beat burst
        do_reset();
        burst_len = {4'd0, 4'd0, 4'd0, 4'd15};
        src_sel   = {3'd0, 3'd0, 3'd0, 3'd4};
        req       = 4'b0001;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 8'(gnt), 8'h0);
        chk("arst_xv", 8'(xfer_valid), 8'h0);
        chk("arst_sel", 8'(read_en), 8'd3);
        chk("arst_done", 8'(done), 8'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        req = 4'd0;

        // random traffic with drops, re-requests and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
                burst_len[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                                   : 4'($urandom_range(0, 2));
            end
            req     = r;
            src_sel = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
